// File: rtl/gait_sequencer_pkg.sv
// Shared definitions for the gait sequencer: default timing at 12 MHz, the
// per-step action decode type and small elaboration helpers.
package gait_sequencer_pkg;

  localparam int T_20MS_12M   = 240000;  // PWM frame
  localparam int T_60MS_12M   = 720000;  // gait step
  localparam int PW_0P5MS_12M = 6000;    // pulse width at position 0
  localparam int PW_STEP_12M  = 94;      // extra cycles per position LSB

  // What the address/step-counter logic does on the coming edge.
  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_FWD,
    STEP_REV,
    STEP_HOME
  } step_act_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int center_pos(input int dw);
    return 1 << (dw - 1);
  endfunction

endpackage

// File: rtl/gait_sequencer_if.sv
// Control/status bundle of the gait sequencer.
//   run, dir, home : playback control from the robot wrapper
//   trim           : signed 8-bit offset per channel (only with GAIT_TRIM_EN)
//   servo          : one PWM output per channel
//   addr           : current step address
//   step_tick      : one-cycle pulse on each stepping address change
//   led0           : run indicator
// Modport master is the wrapper side, slave is the sequencer.
interface gait_sequencer_if #(
  parameter int NCH = 3,
  parameter int AW  = 5
);
  import gait_sequencer_pkg::*;

  logic           run;
  logic           dir;
  logic           home;
`ifdef GAIT_TRIM_EN
  logic [NCH*8-1:0] trim;
`endif
  logic [NCH-1:0] servo;
  logic [AW-1:0]  addr;
  logic           step_tick;
  logic           led0;

  modport master (
    output run, dir, home,
`ifdef GAIT_TRIM_EN
    output trim,
`endif
    input  servo, addr, step_tick, led0
  );

  modport slave (
    input  run, dir, home,
`ifdef GAIT_TRIM_EN
    input  trim,
`endif
    output servo, addr, step_tick, led0
  );

endinterface

// File: rtl/gait_sequencer_servo_pwm.sv
// One PWM channel. Holds the shadow position, which only changes at the frame
// wrap so a pulse never changes width mid-frame, and compares the shared frame
// count against the pulse width derived from it.
// Ports: clk, rstn (sync, active low), frame_cnt (shared), frame_end (last
// cycle of frame), pend_pos (pending pose from ROM), trim (GAIT_TRIM_EN only),
// servo (registered PWM output).
module gait_sequencer_servo_pwm
  import gait_sequencer_pkg::*;
#(
  parameter int DW          = 8,
  parameter int CW          = 18,
  parameter int PW_MIN_CYC  = PW_0P5MS_12M,
  parameter int PW_STEP_CYC = PW_STEP_12M
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CW-1:0] frame_cnt,
  input  logic          frame_end,
  input  logic [DW-1:0] pend_pos,
`ifdef GAIT_TRIM_EN
  input  logic [7:0]    trim,
`endif
  output logic          servo
);

  logic [DW-1:0] shadow;
  logic [DW-1:0] shadow_nxt;
  logic [CW-1:0] width;

`ifdef GAIT_TRIM_EN
  int trim_sum;

  always_comb begin
    trim_sum = int'(pend_pos) + int'($signed(trim));
    if (trim_sum < 0)
      shadow_nxt = '0;
    else if (trim_sum > (2**DW - 1))
      shadow_nxt = '1;
    else
      shadow_nxt = DW'(trim_sum);
  end
`else
  assign shadow_nxt = pend_pos;
`endif

  // CW is sized by the top to hold the widest pulse, so this cannot wrap.
  assign width = CW'(PW_MIN_CYC) + CW'(shadow) * CW'(PW_STEP_CYC);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shadow <= DW'(center_pos(DW));
      servo  <= 1'b0;
    end else begin
      servo <= (frame_cnt < width);
      if (frame_end)
        shadow <= shadow_nxt;
    end
  end

endmodule

// File: rtl/gait_sequencer.sv
// Multi-channel gait sequencer: steps through a ROM of packed NCH-servo poses
// at STEP_CYC clocks per step and drives one PWM output per servo with a
// FRAME_CYC frame. ROM word = NCH*DW bits, channel 0 in the LSBs; contents come
// from ROM_INIT (2**AW words, word 0 in the LSBs).
// Optional feature: GAIT_TRIM_EN adds a signed per-channel trim applied with
// saturation when the shadow position loads.
// Ports: clk, rstn (sync, active low), bus (gait_sequencer_if.slave).
module gait_sequencer
  import gait_sequencer_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int AW          = 5,
  parameter int DW          = 8,
  parameter int LEN         = 32,
  parameter int STEP_CYC    = T_60MS_12M,
  parameter int FRAME_CYC   = T_20MS_12M,
  parameter int PW_MIN_CYC  = PW_0P5MS_12M,
  parameter int PW_STEP_CYC = PW_STEP_12M,
  parameter logic [(2**AW)*NCH*DW-1:0] ROM_INIT =
    {((2**AW)*NCH){1'b1, {(DW-1){1'b0}}}}
) (
  input  logic clk,
  input  logic rstn,
  gait_sequencer_if.slave bus
);

  localparam int WW     = NCH * DW;
  localparam int PW_MAX = PW_MIN_CYC + (2**DW - 1) * PW_STEP_CYC;
  localparam int CW     = $clog2(max_int(PW_MAX, FRAME_CYC) + 1);
  localparam int SW     = $clog2(STEP_CYC);

  logic [SW-1:0]  step_cnt;
  logic [AW-1:0]  addr;
  logic           step_tick;
  logic           led0;
  step_act_e      act;
  logic [WW-1:0]  rom_q;
  logic [CW-1:0]  frame_cnt;
  logic           frame_end;
  logic [NCH-1:0] servo;

  // home wins over a terminal count in the same cycle.
  always_comb begin
    act = STEP_HOLD;
    if (bus.home)
      act = STEP_HOME;
    else if (bus.run && (step_cnt == SW'(STEP_CYC - 1)))
      act = bus.dir ? STEP_REV : STEP_FWD;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      step_cnt  <= '0;
      addr      <= '0;
      step_tick <= 1'b0;
      led0      <= 1'b0;
    end else begin
      led0      <= bus.run;
      step_tick <= 1'b0;
      case (act)
        STEP_HOME: begin
          addr     <= '0;
          step_cnt <= '0;
        end
        STEP_FWD: begin
          addr      <= (addr == AW'(LEN - 1)) ? '0 : addr + 1'b1;
          step_cnt  <= '0;
          step_tick <= 1'b1;
        end
        STEP_REV: begin
          addr      <= (addr == '0) ? AW'(LEN - 1) : addr - 1'b1;
          step_cnt  <= '0;
          step_tick <= 1'b1;
        end
        default: begin
          // paused: hold the count so a resume continues the step
          if (bus.run)
            step_cnt <= step_cnt + 1'b1;
        end
      endcase
    end
  end

  // Synchronous ROM read; its output register doubles as the pending pose.
  always_ff @(posedge clk) begin
    rom_q <= ROM_INIT[int'(addr) * WW +: WW];
  end

  assign frame_end = (frame_cnt == CW'(FRAME_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rstn)
      frame_cnt <= '0;
    else
      frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gait_sequencer_servo_pwm #(
      .DW          (DW),
      .CW          (CW),
      .PW_MIN_CYC  (PW_MIN_CYC),
      .PW_STEP_CYC (PW_STEP_CYC)
    ) u_pwm (
      .clk       (clk),
      .rstn      (rstn),
      .frame_cnt (frame_cnt),
      .frame_end (frame_end),
      .pend_pos  (rom_q[i*DW +: DW]),
`ifdef GAIT_TRIM_EN
      .trim      (bus.trim[i*8 +: 8]),
`endif
      .servo     (servo[i])
    );
  end

  assign bus.servo     = servo;
  assign bus.addr      = addr;
  assign bus.step_tick = step_tick;
  assign bus.led0      = led0;

endmodule

// File: tb/tb_gait_sequencer.sv
module tb_gait_sequencer;

  localparam int NCH    = 3;
  localparam int AW     = 5;
  localparam int DW     = 6;
  localparam int LEN    = 4;
  localparam int STEP   = 20;
  localparam int FRAME  = 100;
  localparam int PWMIN  = 10;
  localparam int PWSTEP = 1;
  localparam int CENTRE = 32;

  // pose table for the used steps; unused ROM words hold 50 to expose bad wraps
  localparam int ROM_T [4][3] = '{'{5, 12, 33}, '{40, 60, 3}, '{20, 30, 62}, '{63, 0, 7}};

  function automatic int rom_pos(input int a, input int c);
    if (a < LEN) return ROM_T[a][c];
    return 50;
  endfunction

  function automatic logic [(2**AW)*NCH*DW-1:0] build_rom();
    logic [(2**AW)*NCH*DW-1:0] v;
    v = '0;
    for (int a = 0; a < 2**AW; a++)
      for (int c = 0; c < NCH; c++)
        v[(a*NCH + c)*DW +: DW] = DW'(rom_pos(a, c));
    return v;
  endfunction

  localparam logic [(2**AW)*NCH*DW-1:0] ROM_V = build_rom();

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  gait_sequencer_if #(.NCH(NCH), .AW(AW)) bus ();

  gait_sequencer #(
    .NCH(NCH), .AW(AW), .DW(DW), .LEN(LEN), .STEP_CYC(STEP), .FRAME_CYC(FRAME),
    .PW_MIN_CYC(PWMIN), .PW_STEP_CYC(PWSTEP), .ROM_INIT(ROM_V)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Saturated position after trim, from the rules: clamp to [0, 2**DW-1].
  function automatic int shadow_of(input int p, input logic signed [7:0] t);
    int v;
    v = p + int'(t);
    if (v < 0) return 0;
    if (v > 2**DW - 1) return 2**DW - 1;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  int m_cnt, m_addr, m_pos;
  int m_pend[NCH], m_shadow[NCH];
  bit m_tick, m_led, started;
  bit m_servo[NCH];

  initial begin
    m_cnt = 0; m_addr = 0; m_pos = 0; m_tick = 0; m_led = 0; started = 0;
    for (int c = 0; c < NCH; c++) begin
      m_pend[c] = 0; m_shadow[c] = CENTRE; m_servo[c] = 0;
    end
    forever begin
      int new_pend[NCH];
      @(posedge clk);
      // ROM data trails the address by one cycle
      for (int c = 0; c < NCH; c++) new_pend[c] = rom_pos(m_addr, c);
      if (!rstn) begin
        m_cnt = 0; m_addr = 0; m_tick = 0; m_led = 0; m_pos = 0;
        for (int c = 0; c < NCH; c++) begin
          m_shadow[c] = CENTRE; m_servo[c] = 0;
        end
      end else begin
        m_led  = bus.run;
        m_tick = 0;
        if (bus.home) begin
          m_addr = 0; m_cnt = 0;
        end else if (bus.run) begin
          m_cnt++;
          if (m_cnt == STEP) begin
            m_cnt  = 0;
            m_tick = 1;
            m_addr = bus.dir ? (m_addr + LEN - 1) % LEN : (m_addr + 1) % LEN;
          end
        end
        for (int c = 0; c < NCH; c++)
          m_servo[c] = (m_pos < PWMIN + m_shadow[c] * PWSTEP);
        if (m_pos == FRAME - 1)
          for (int c = 0; c < NCH; c++)
`ifdef GAIT_TRIM_EN
            m_shadow[c] = shadow_of(m_pend[c], bus.trim[c*8 +: 8]);
`else
            m_shadow[c] = shadow_of(m_pend[c], 8'sd0);
`endif
        m_pos = (m_pos + 1) % FRAME;
      end
      m_pend  = new_pend;
      started = 1;
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("addr", 32'(bus.addr), 32'(m_addr));
        chk("step_tick", 32'(bus.step_tick), 32'(m_tick));
        chk("led0", 32'(bus.led0), 32'(m_led));
        for (int c = 0; c < NCH; c++)
          chk($sformatf("servo%0d", c), 32'(bus.servo[c]), 32'(m_servo[c]));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_rise(input int ch, output bit ok);
    int n = 0;
    while (bus.servo[ch] === 1'b1 && n < 300) begin @(negedge clk); n++; end
    while (bus.servo[ch] !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    ok = (n < 600);
  endtask

  task automatic measure_high(input int ch, output int w);
    bit ok;
    int n = 0;
    w = 0;
    wait_rise(ch, ok);
    if (!ok) begin
      w = -1;
      return;
    end
    while (bus.servo[ch] === 1'b1 && n < 300) begin w++; @(negedge clk); n++; end
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.step_tick !== 1'b1 && cyc < 200);
    if (cyc >= 200) cyc = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int w, w2, c;
    bit ok;
    int exp_fwd[4] = '{1, 2, 3, 0};

    rstn = 1'b0;
    bus.run = 1'b1;
    bus.dir = 1'b0;
    bus.home = 1'b0;
`ifdef GAIT_TRIM_EN
    bus.trim = '0;
`endif
    repeat (4) @(negedge clk);
    chk("rst_servo", 32'(bus.servo), 0);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_led0", 32'(bus.led0), 0);
    chk("rst_tick", 32'(bus.step_tick), 0);

    bus.run = 1'b0;
    rstn = 1'b1;
    measure_high(0, w);
    chk("pw_centre", w, 42);
    measure_high(0, w);
    chk("pw_rom0", w, 15);

    // forward: wrap at LEN-1
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(c);
      chk("tick_fwd", c, 20);
      chk("addr_fwd", 32'(bus.addr), exp_fwd[i]);
    end

    // reverse from 0, then pause/resume
    bus.dir = 1'b1;
    wait_tick(c);
    chk("tick_rev", c, 20);
    chk("addr_rev", 32'(bus.addr), 3);
    repeat (7) @(negedge clk);
    bus.run = 1'b0;
    repeat (10) @(negedge clk);
    chk("pause_tick", 32'(bus.step_tick), 0);
    bus.run = 1'b1;
    wait_tick(c);
    chk("tick_resume", c, 13);
    chk("addr_resume", 32'(bus.addr), 2);

    // home on the terminal-count cycle
    repeat (19) @(negedge clk);
    bus.home = 1'b1;
    @(negedge clk);
    bus.home = 1'b0;
    chk("home_addr", 32'(bus.addr), 0);
    chk("home_tick", 32'(bus.step_tick), 0);
    wait_tick(c);
    chk("tick_home", c, 20);
    chk("addr_home", 32'(bus.addr), 3);

    // mid-frame step 5 -> 40
    bus.run = 1'b0;
    bus.dir = 1'b0;
    bus.home = 1'b1;
    @(negedge clk);
    bus.home = 1'b0;
    repeat (250) @(negedge clk);
    wait_rise(0, ok);
    chk("rise_ok", 32'(ok), 1);
    repeat (87) @(negedge clk);
    bus.run = 1'b1;
    fork
      measure_high(0, w);
      begin
        wait_tick(c);
        bus.run = 1'b0;
      end
    join
    chk("tick_mid", c, 20);
    chk("pw_mid_old", w, 15);
    measure_high(0, w);
    chk("pw_mid_new", w, 50);
    chk("addr_mid", 32'(bus.addr), 1);

    // trim / raw widths at addr 1 (pos 60 and 3)
`ifdef GAIT_TRIM_EN
    bus.trim = {8'hF8, 8'd10, 8'd0};
`endif
    repeat (100) @(negedge clk);
    measure_high(1, w);
    measure_high(2, w2);
`ifdef GAIT_TRIM_EN
    chk("pw_trim_hi", w, 73);
    chk("pw_trim_lo", w2, 10);
`else
    chk("pw_raw_60", w, 70);
    chk("pw_raw_3", w2, 13);
`endif

    // reset in the middle of a pulse
    wait_rise(0, ok);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_servo", 32'(bus.servo), 0);
    chk("midrst_addr", 32'(bus.addr), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    measure_high(0, w);
    chk("pw_after_rst", w, 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
